bird_collision_score: RTL and testbench

- Game-logic stage directly downstream of the bar environment block.
- Consumes the 8 bar opening positions and sizes plus the bird's screen coordinates each game tick.
- Detects bird/bar collisions and counts cleared bars as score.
- Manages lives and advances the level. The level output feeds back to the environment's level input.
- Runs on the environment clock and honours the same pause input.

---
 rtl/game_pkg.sv | 39 +++
 rtl/bar_hit_check.sv | 35 +++
 rtl/bird_collision_score.sv | 144 ++++++++++++++
 tb/tb_bird_collision_score.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-logic types and constants for the bird game.
// Holds the FSM state enum, screen geometry, coordinate type and a BCD helper.
package game_pkg;

    localparam int NUM_BARS = 8;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        PLAY,
        HIT,
        WIN,
        OVER
    } state_t;

    // Increment a 4-digit BCD value, holding at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (c) begin
                    if (r[4*d +: 4] == 4'd9) begin
                        r[4*d +: 4] = 4'd0;
                    end else begin
                        r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bar_hit_check.sv
// Combinational occupancy/collision test for one bar column.
// Ports: bird_x/bird_y (bird top-left), pos/op (opening top and size) -> in_col, collide.
module bar_hit_check
    import game_pkg::*;
#(
    parameter int COL_X  = 80,
    parameter int BAR_W  = 16,
    parameter int BIRD_H = 10
) (
    input  coord_t bird_x,
    input  coord_t bird_y,
    input  coord_t pos,
    input  coord_t op,
    output logic   in_col,
    output logic   collide
);

    localparam logic [10:0] X_LO = 11'(COL_X);
    localparam logic [10:0] X_HI = 11'(COL_X + BAR_W);

    logic [10:0] x;
    logic [10:0] bird_bot;
    logic [10:0] open_bot;

    // 11-bit sums so bottom edges cannot wrap.
    assign x        = {1'b0, bird_x};
    assign bird_bot = {1'b0, bird_y} + 11'(BIRD_H);
    assign open_bot = {1'b0, pos} + {1'b0, op};

    assign in_col  = (x >= X_LO) && (x < X_HI);
    // A zero-size opening marks the column as disabled.
    assign collide = in_col && (op != '0)
                     && ((bird_y < pos) || (bird_bot > open_bot));

endmodule

// File: rtl/bird_collision_score.sv
// Bird/bar collision, score, lives and level manager (registered outputs).
// Ports: clkenv, rst, pause, bird_x/y, bar buses -> level, score, lives, hit,
// freeze, restart, game_over; score_bcd only when SCORE_BCD_EN is defined.
module bird_collision_score
    import game_pkg::*;
#(
    parameter int BAR_X0      = 80,
    parameter int BAR_PITCH   = 64,
    parameter int BAR_W       = 16,
    parameter int BIRD_H      = 10,
    parameter int LEVEL_END_X = 620,
    parameter int HIT_HOLD    = 60,
    parameter int LIVES_INIT  = 3,
    parameter int MAX_LEVEL   = 10
) (
    input  logic                    clkenv,
    input  logic                    rst,
    input  logic                    pause,
    input  coord_t                  bird_x,
    input  coord_t                  bird_y,
    input  logic [10*NUM_BARS-1:0]  bar_pos_bus,
    input  logic [10*NUM_BARS-1:0]  bar_op_bus,
    output logic [9:0]              level,
    output logic [15:0]             score,
    output logic [2:0]              lives,
    output logic                    hit,
    output logic                    freeze,
    output logic                    restart,
    output logic                    game_over
`ifdef SCORE_BCD_EN
    ,
    output logic [15:0]             score_bcd
`endif
);

    localparam int CW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

    state_t              state;
    logic [CW-1:0]       hold_cnt;
    logic [NUM_BARS-1:0] prev_in_col;
    logic [NUM_BARS-1:0] in_col;
    logic [NUM_BARS-1:0] collide;
    logic [NUM_BARS-1:0] past;
    logic [NUM_BARS-1:0] enabled;
    logic                any_col;
    logic                any_exit;
    logic                at_end;

    for (genvar i = 0; i < NUM_BARS; i++) begin : g_col
        bar_hit_check #(
            .COL_X  (BAR_X0 + i*BAR_PITCH),
            .BAR_W  (BAR_W),
            .BIRD_H (BIRD_H)
        ) u_chk (
            .bird_x  (bird_x),
            .bird_y  (bird_y),
            .pos     (bar_pos_bus[10*i +: 10]),
            .op      (bar_op_bus[10*i +: 10]),
            .in_col  (in_col[i]),
            .collide (collide[i])
        );
        assign past[i]    = {1'b0, bird_x}
                            >= 11'(BAR_X0 + i*BAR_PITCH + BAR_W);
        assign enabled[i] = bar_op_bus[10*i +: 10] != '0;
    end

    assign any_col  = |collide;
    // Exit only counts when leaving through the right edge of a live column.
    assign any_exit = |(prev_in_col & ~in_col & past & enabled);
    assign at_end   = {1'b0, bird_x} >= 11'(LEVEL_END_X);

    always_ff @(posedge clkenv) begin
        if (rst) begin
            state       <= PLAY;
            hold_cnt    <= '0;
            prev_in_col <= '0;
            level       <= 10'd1;
            score       <= '0;
            lives       <= 3'(LIVES_INIT);
            hit         <= 1'b0;
            freeze      <= 1'b0;
            restart     <= 1'b0;
            game_over   <= 1'b0;
`ifdef SCORE_BCD_EN
            score_bcd   <= '0;
`endif
        end else if (pause) begin
            hit     <= 1'b0;
            restart <= 1'b0;
        end else begin
            hit     <= 1'b0;
            restart <= 1'b0;
            unique case (state)
                PLAY: begin
                    prev_in_col <= in_col;
                    if (any_col) begin
                        hit      <= 1'b1;
                        freeze   <= 1'b1;
                        hold_cnt <= CW'(HIT_HOLD - 1);
                        lives    <= lives - 3'd1;
                        if (lives == 3'd1) begin
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            state <= HIT;
                        end
                    end else begin
                        if (any_exit && score != 16'hFFFF)
                            score <= score + 16'd1;
`ifdef SCORE_BCD_EN
                        if (any_exit)
                            score_bcd <= bcd_inc(score_bcd);
`endif
                        if (at_end)
                            state <= WIN;
                    end
                end
                HIT: begin
                    if (hold_cnt == '0) begin
                        freeze      <= 1'b0;
                        restart     <= 1'b1;
                        prev_in_col <= '0;
                        state       <= PLAY;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                WIN: begin
                    if (level < 10'(MAX_LEVEL))
                        level <= level + 10'd1;
                    restart     <= 1'b1;
                    prev_in_col <= '0;
                    state       <= PLAY;
                end
                OVER: begin
                    freeze    <= 1'b1;
                    game_over <= 1'b1;
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_bird_collision_score.sv
// Self-checking bench for bird_collision_score.
// Vector table plus hand sequences, checked through an expected-value queue.
module tb_bird_collision_score;

    typedef struct {
        string       name;
        bit          rst;
        bit          p;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [9:0]  level;
        logic [15:0] score;
        logic [2:0]  lives;
        bit          hit;
        bit          freeze;
        bit          restart;
        bit          over;
    } vec_t;

    logic        clkenv = 1'b0;
    logic        rst    = 1'b1;
    logic        pause  = 1'b0;
    logic [9:0]  bird_x = '0;
    logic [9:0]  bird_y = '0;
    logic [79:0] bar_pos_bus = '0;
    logic [79:0] bar_op_bus  = '0;
    logic [9:0]  level;
    logic [15:0] score;
    logic [2:0]  lives;
    logic        hit;
    logic        freeze;
    logic        restart;
    logic        game_over;
`ifdef SCORE_BCD_EN
    logic [15:0] score_bcd;
`endif

    int   checks   = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clkenv = ~clkenv;

    bird_collision_score dut (
        .clkenv      (clkenv),
        .rst         (rst),
        .pause       (pause),
        .bird_x      (bird_x),
        .bird_y      (bird_y),
        .bar_pos_bus (bar_pos_bus),
        .bar_op_bus  (bar_op_bus),
        .level       (level),
        .score       (score),
        .lives       (lives),
        .hit         (hit),
        .freeze      (freeze),
        .restart     (restart),
        .game_over   (game_over)
`ifdef SCORE_BCD_EN
        ,
        .score_bcd   (score_bcd)
`endif
    );

    function automatic vec_t mk(string n, bit r, bit p, int x, int y,
                                int lv, int sc, int li,
                                bit h, bit f, bit rs, bit ov);
        vec_t v;
        v.name = n; v.rst = r; v.p = p;
        v.x = 10'(x); v.y = 10'(y);
        v.level = 10'(lv); v.score = 16'(sc); v.lives = 3'(li);
        v.hit = h; v.freeze = f; v.restart = rs; v.over = ov;
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(int s);
        return {4'((s / 1000) % 10), 4'((s / 100) % 10),
                4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic set_bar(int i, int pos, int op);
        bar_pos_bus[10*i +: 10] = 10'(pos);
        bar_op_bus[10*i +: 10]  = 10'(op);
    endtask

    task automatic check_out();
        vec_t e;
        bit   ok;
        e = sb.pop_front();
        checks++;
        ok = (level == e.level) && (score == e.score) && (lives == e.lives)
             && (hit == e.hit) && (freeze == e.freeze)
             && (restart == e.restart) && (game_over == e.over);
`ifdef SCORE_BCD_EN
        ok = ok && (score_bcd == to_bcd(int'(e.score)));
`endif
        if (!ok) begin
            failures++;
            $display("FAIL %s: got lv=%0d sc=%0d li=%0d h=%b f=%b rs=%b ov=%b want lv=%0d sc=%0d li=%0d h=%b f=%b rs=%b ov=%b",
                     e.name, level, score, lives, hit, freeze, restart,
                     game_over, e.level, e.score, e.lives, e.hit,
                     e.freeze, e.restart, e.over);
`ifdef SCORE_BCD_EN
            $display("  bcd got %h want %h", score_bcd,
                     to_bcd(int'(e.score)));
`endif
        end
    endtask

    task automatic apply(vec_t v);
        rst    = v.rst;
        pause  = v.p;
        bird_x = v.x;
        bird_y = v.y;
        sb.push_back(v);
        @(posedge clkenv);
        #1;
        check_out();
    endtask

    // Freeze window after a hit, then the restart pulse and one idle tick.
    task automatic hold_release(string n, int cnt, int lv, int sc, int li);
        for (int k = 0; k < cnt; k++)
            apply(mk(n, 0, 0, 100, 250, lv, sc, li, 0, 1, 0, 0));
        apply(mk({n, "_restart"}, 0, 0, 100, 250, lv, sc, li, 0, 0, 1, 0));
        apply(mk({n, "_after"}, 0, 0, 100, 250, lv, sc, li, 0, 0, 0, 0));
    endtask

    initial begin
        tbl.push_back(mk("pass_x140", 0, 0, 140, 250, 1, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk("pass_x144", 0, 0, 144, 250, 1, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk("pass_x150", 0, 0, 150, 250, 1, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk("pass_x159", 0, 0, 159, 250, 1, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk("pass_x160", 0, 0, 160, 250, 1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk("pass_x165", 0, 0, 165, 250, 1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk("edge_bot_in", 0, 0, 150, 290, 1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk("edge_bot_out", 0, 0, 160, 290, 1, 2, 3, 0, 0, 0, 0));

        set_bar(1, 240, 60);
        apply(mk("reset", 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0));
        foreach (tbl[i]) apply(tbl[i]);

        apply(mk("hit_bot", 0, 0, 150, 295, 1, 2, 2, 1, 1, 0, 0));
        hold_release("hold_bot", 59, 1, 2, 2);

        apply(mk("hit_top", 0, 0, 150, 239, 1, 2, 1, 1, 1, 0, 0));
        hold_release("hold_top", 59, 1, 2, 1);

        apply(mk("hit_last", 0, 0, 150, 295, 1, 2, 0, 1, 1, 0, 1));
        apply(mk("over_sticky", 0, 0, 150, 295, 1, 2, 0, 0, 1, 0, 1));
        apply(mk("over_end", 0, 0, 620, 250, 1, 2, 0, 0, 1, 0, 1));
        apply(mk("over_rst", 1, 0, 150, 295, 1, 0, 3, 0, 0, 0, 0));

        apply(mk("win_enter", 0, 0, 620, 250, 1, 0, 3, 0, 0, 0, 0));
        apply(mk("win_level", 0, 0, 100, 250, 2, 0, 3, 0, 0, 1, 0));
        apply(mk("win_after", 0, 0, 100, 250, 2, 0, 3, 0, 0, 0, 0));

        apply(mk("pause_col", 0, 1, 150, 295, 2, 0, 3, 0, 0, 0, 0));
        apply(mk("pause_col2", 0, 1, 150, 295, 2, 0, 3, 0, 0, 0, 0));
        apply(mk("hit_unpause", 0, 0, 150, 295, 2, 0, 2, 1, 1, 0, 0));
        for (int k = 0; k < 3; k++)
            apply(mk("pause_drop", 0, 1, 100, 250, 2, 0, 2, 0, 1, 0, 0));
        hold_release("hold_pause", 59, 2, 0, 2);

        set_bar(0, 100, 0);
        apply(mk("dis_in_y0", 0, 0, 85, 0, 2, 0, 2, 0, 0, 0, 0));
        apply(mk("dis_in_y400", 0, 0, 90, 400, 2, 0, 2, 0, 0, 0, 0));
        apply(mk("dis_exit", 0, 0, 96, 0, 2, 0, 2, 0, 0, 0, 0));

        set_bar(2, 240, 60);
        apply(mk("cx_in", 0, 0, 159, 250, 2, 0, 2, 0, 0, 0, 0));
        apply(mk("cx_hit", 0, 0, 208, 0, 2, 0, 1, 1, 1, 0, 0));
        hold_release("hold_cx", 59, 2, 0, 1);

        for (int l = 3; l <= 11; l++) begin
            apply(mk("lvl_enter", 0, 0, 620, 250, (l - 1 > 10) ? 10 : l - 1,
                     0, 1, 0, 0, 0, 0));
            apply(mk("lvl_up", 0, 0, 100, 250, (l > 10) ? 10 : l,
                     0, 1, 0, 0, 1, 0));
        end
        apply(mk("lvl_sat", 0, 0, 100, 250, 10, 0, 1, 0, 0, 0, 0));

        apply(mk("rst2", 1, 0, 100, 250, 1, 0, 3, 0, 0, 0, 0));
        for (int k = 1; k <= 12; k++) begin
            apply(mk("clr_in", 0, 0, 150, 250, 1, k - 1, 3, 0, 0, 0, 0));
            apply(mk("clr_out", 0, 0, 160, 250, 1, k, 3, 0, 0, 0, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
